// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
//   arb_state_t : arbiter state (IDLE between packets, LOCKED inside a multi-beat packet)
//   N_REQ_MAX   : largest supported producer count
//   STAT_W      : width of each optional statistics counter
//   rr_next()   : circular successor of a producer index
package fifo_arb_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  localparam int unsigned N_REQ_MAX = 8;
  localparam int unsigned STAT_W    = 16;

  // Successor of idx in 0..n-1, wrapping from n-1 to 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: finds the first asserted request at or after i_ptr,
// scanning circularly (i_ptr, i_ptr+1, .., N-1, 0, ..).
// Ports:
//   i_req [N]  request vector
//   i_ptr [W]  index with highest priority this cycle
//   o_sel [W]  chosen index (equals i_ptr when nothing is requesting)
//   o_any      at least one request is asserted
module rr_pick #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_sel,
  output logic         o_any
);

  logic [W-1:0] w_idx;

  always_comb begin
    o_sel = i_ptr;
    o_any = 1'b0;
    w_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = W'((32'(i_ptr) + k) % N);
      if (!o_any && i_req[w_idx]) begin
        o_sel = w_idx;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin write-side arbiter sharing one FIFO between N_REQ producers. A producer
// that starts a multi-beat packet keeps the FIFO until its last beat is accepted.
// Beats are accepted with zero latency: push/data go straight to the FIFO.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   req      [N_REQ]   per-producer beat valid
//   req_last [N_REQ]   per-producer last-beat flag, qualified by req
//   req_data [N_REQ*WIDTH] producer i at [i*WIDTH +: WIDTH]
//   gnt      [N_REQ]   one-hot, beat of producer i accepted this cycle
//   push, data         FIFO write port
//   full               FIFO full
//   owner              producer holding the lock (meaningful while locked)
//   locked             arbiter is inside a multi-beat packet
// Optional feature macro FIFO_ARB_STATS_EN adds:
//   stat_beats [N_REQ*16]  saturating per-producer accepted-beat counters
//   stat_stall [16]        saturating count of cycles with any request while full
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N_REQ = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_last,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     push,
  output logic [WIDTH-1:0]         data,
  input  logic                     full,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     locked
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0]  stat_beats,
  output logic [STAT_W-1:0]        stat_stall
`endif
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  arb_state_t       r_state;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_owner;

  logic [PTR_W-1:0] w_pick_sel;
  logic             w_pick_any;
  logic [PTR_W-1:0] w_sel;
  logic             w_sel_req;
  logic             w_sel_last;
  logic             w_push;
  logic [WIDTH-1:0] w_mux;

  rr_pick #(
    .N (N_REQ),
    .W (PTR_W)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_sel (w_pick_sel),
    .o_any (w_pick_any)
  );

  // While locked only the owner is eligible; everyone else waits.
  assign w_sel      = (r_state == LOCKED) ? r_owner : w_pick_sel;
  assign w_sel_req  = (r_state == LOCKED) ? req[r_owner] : w_pick_any;
  assign w_sel_last = req_last[w_sel];
  // rstn gates push so nothing reaches the FIFO while the arbiter is held in reset.
  assign w_push     = w_sel_req & ~full & rstn;

  always_comb begin
    w_mux = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_sel == PTR_W'(k)) w_mux = req_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    gnt = '0;
    if (w_push) gnt[w_sel] = 1'b1;
  end

  assign push   = w_push;
  // Show the selected beat whenever it is valid (also while blocked by full), else zero.
  assign data   = w_sel_req ? w_mux : '0;
  assign owner  = r_owner;
  assign locked = (r_state == LOCKED);

  // A blocked cycle (full or no request) leaves state and pointer untouched, so the same
  // producer is retried once the FIFO drains.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else if (w_push) begin
      unique case (r_state)
        IDLE: begin
          if (w_sel_last) begin
            r_rr_ptr <= PTR_W'(rr_next(32'(w_sel), N_REQ));
          end else begin
            r_state <= LOCKED;
            r_owner <= w_sel;
          end
        end
        LOCKED: begin
          if (w_sel_last) begin
            r_state  <= IDLE;
            r_rr_ptr <= PTR_W'(rr_next(32'(r_owner), N_REQ));
          end
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] r_beats [N_REQ];
  logic [STAT_W-1:0] r_stall;

  for (genvar i = 0; i < N_REQ; i++) begin : g_beats
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_beats[i] <= '0;
      end else if (gnt[i] && (r_beats[i] != '1)) begin
        r_beats[i] <= r_beats[i] + 1'b1;
      end
    end
    assign stat_beats[i*STAT_W +: STAT_W] = r_beats[i];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall <= '0;
    end else if ((|req) && full && (r_stall != '1)) begin
      r_stall <= r_stall + 1'b1;
    end
  end
  assign stat_stall = r_stall;
`endif

endmodule
